// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable width, parity, stop bits and baud divisor.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_param #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] din,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk_req,
`endif
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  generate
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
      $error("uart_tx_param: CLK_DIV must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);

`ifdef UART_TX_BREAK_EN
  localparam int FRAME_CYC = (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS) * CLK_DIV;
  localparam int BRK_W     = $clog2(FRAME_CYC);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`endif

  state_t               state_reg;
  logic [CNT_W-1:0]     baud_cnt_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic                 stop_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 tx_reg;
  logic                 ready_reg;
  logic                 busy_reg;
  logic                 done_reg;
`ifdef UART_TX_BREAK_EN
  logic [BRK_W-1:0]     brk_cnt_reg;
  logic                 brk_mark_reg;
`endif

  logic tick;
  logic parity_bit;

  assign tick       = (baud_cnt_reg == CNT_W'(CLK_DIV - 1));
  // Parity comes from the untouched copy, since shift_reg is consumed bit by bit.
  assign parity_bit = (PARITY == 1) ? ~(^data_reg) : (^data_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      shift_reg    <= '0;
      data_reg     <= '0;
      tx_reg       <= 1'b1;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_reg  <= '0;
      brk_mark_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (state_reg != IDLE) begin
        baud_cnt_reg <= tick ? '0 : baud_cnt_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (brk_req) begin
            state_reg    <= BRK;
            tx_reg       <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            baud_cnt_reg <= '0;
            brk_cnt_reg  <= '0;
            brk_mark_reg <= 1'b0;
          end else
`endif
          if (tx_start) begin
            state_reg    <= START;
            tx_reg       <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            baud_cnt_reg <= '0;
            shift_reg    <= din;
            data_reg     <= din;
          end
        end
        START: begin
          if (tick) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
            tx_reg      <= shift_reg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                state_reg <= PAR;
                tx_reg    <= parity_bit;
              end else begin
                state_reg    <= STOP;
                tx_reg       <= 1'b1;
                stop_cnt_reg <= 1'b0;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              tx_reg      <= shift_reg[1];
            end
          end
        end
        PAR: begin
          if (tick) begin
            state_reg    <= STOP;
            tx_reg       <= 1'b1;
            stop_cnt_reg <= 1'b0;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
              state_reg <= IDLE;
              ready_reg <= 1'b1;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        BRK: begin
          if (!brk_mark_reg) begin
            // Hold low for a full frame time, then until the request drops.
            if (brk_cnt_reg != BRK_W'(FRAME_CYC - 1)) begin
              brk_cnt_reg <= brk_cnt_reg + 1'b1;
            end else if (!brk_req) begin
              brk_mark_reg <= 1'b1;
              tx_reg       <= 1'b1;
              baud_cnt_reg <= '0;
            end
          end else if (tick) begin
            state_reg    <= IDLE;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            brk_mark_reg <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_reg;
  assign tx_ready = ready_reg;
  assign tx_busy  = busy_reg;
  assign tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four configurations, frames compared against hand-built bit patterns.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int DIV_P [4] = '{4, 4, 4, 3};
  localparam int DB_P  [4] = '{8, 8, 8, 7};
  localparam int PAR_P [4] = '{0, 2, 1, 0};
  localparam int SB_P  [4] = '{1, 1, 1, 2};

  logic       rst;
  logic       start [4];
  logic [7:0] din   [4];
  logic       brk   [4];
  logic       tx_w  [4];
  logic       ready [4];
  logic       busy  [4];
  logic       done  [4];

  int n_checks = 0;
  int n_pass   = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      uart_tx_param #(
        .CLK_DIV  (DIV_P[gi]),
        .DATA_BITS(DB_P[gi]),
        .PARITY   (PAR_P[gi]),
        .STOP_BITS(SB_P[gi])
      ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .tx_start(start[gi]),
        .din     (din[gi][DB_P[gi]-1:0]),
`ifdef UART_TX_BREAK_EN
        .brk_req (brk[gi]),
`endif
        .tx_ready(ready[gi]),
        .tx      (tx_w[gi]),
        .tx_busy (busy[gi]),
        .tx_done (done[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-12s got %0h exp %0h ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request at the falling edge; returns just after the accepting rising edge.
  task automatic send(input int d, input logic [7:0] v);
    @(negedge clk);
    start[d] = 1'b1;
    din[d]   = v;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
  endtask

  // Called just after the accept edge. frame[0] is the start bit; each bit is sampled every cycle.
  task automatic check_frame(input int d, input logic [15:0] frame, input int nbits,
                             input int div, input string tag);
    int         anomalies;
    logic [3:0] seen;
    logic [3:0] want;
    anomalies = 0;
    for (int b = 0; b < nbits; b++) begin
      seen = '0;
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        seen[c] = tx_w[d];
        if (ready[d] !== 1'b0 || busy[d] !== 1'b1 || done[d] !== 1'b0) anomalies++;
      end
      want = frame[b] ? 4'((1 << div) - 1) : 4'h0;
      check($sformatf("%s b%0d", tag, b), 32'(seen), 32'(want));
    end
    check($sformatf("%s hs", tag), 32'(anomalies), 32'd0);
    @(negedge clk);
    check($sformatf("%s end", tag), {28'd0, done[d], ready[d], busy[d], tx_w[d]}, 32'hD);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0;
      din[i]   = '0;
      brk[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst dut0", {28'd0, done[0], ready[0], busy[0], tx_w[0]}, 32'h5);
    check("rst dut3", {28'd0, done[3], ready[3], busy[3], tx_w[3]}, 32'h5);
    rst = 1'b0;
    @(negedge clk);

    // 8N1, 0xA5
    send(0, 8'hA5);
    check_frame(0, 16'b1101001010, 10, 4, "t1");
    @(negedge clk);
    check("t1 pulse", 32'(done[0]), 32'd0);

    // Parity frames: even 0x07 -> 1, odd 0x07 -> 0, even 0x00 -> 0
    send(1, 8'h07);
    check_frame(1, 16'b11000001110, 11, 4, "t2 ev07");
    send(2, 8'h07);
    check_frame(2, 16'b10000001110, 11, 4, "t2 od07");
    send(1, 8'h00);
    check_frame(1, 16'b10000000000, 11, 4, "t2 ev00");

    // 7 data, 2 stop, back-to-back with tx_start held
    @(negedge clk);
    start[3] = 1'b1;
    din[3]   = 8'h55;
    @(posedge clk);
    #1;
    din[3] = 8'h2A;
    check_frame(3, 16'b1110101010, 10, 3, "t3 f1");
    @(posedge clk);
    #1;
    start[3] = 1'b0;
    check_frame(3, 16'b1101010100, 10, 3, "t3 f2");
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_w[3] !== 1'b1 || ready[3] !== 1'b1) bad++;
    end
    check("t3 idle", 32'(bad), 32'd0);

    // Request while busy is ignored and din changes do not leak into the frame
    send(0, 8'h3C);
    fork
      check_frame(0, 16'b1001111000, 10, 4, "t4");
      begin
        repeat (10) @(negedge clk);
        start[0] = 1'b1;
        din[0]   = 8'hFF;
        @(negedge clk);
        start[0] = 1'b0;
      end
    join
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
    end
    check("t4 idle", 32'(bad), 32'd0);

    // Reset during data bit 3 (cycles 17..20 after accept)
    send(0, 8'h00);
    repeat (18) @(negedge clk);
    check("t5 pre", 32'(tx_w[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t5 rst", {28'd0, done[0], ready[0], busy[0], tx_w[0]}, 32'h5);
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || done[0] !== 1'b0) bad++;
    end
    check("t5 quiet", 32'(bad), 32'd0);
    send(0, 8'h81);
    check_frame(0, 16'b1100000010, 10, 4, "t5 81");

`ifdef UART_TX_BREAK_EN
    // Break: request held 2 cycles together with tx_start
    @(negedge clk);
    brk[0]   = 1'b1;
    start[0] = 1'b1;
    din[0]   = 8'hA5;
    @(negedge clk);
    start[0] = 1'b0;
    check("t6 enter", {28'd0, done[0], ready[0], busy[0], tx_w[0]}, 32'h2);
    @(negedge clk);
    brk[0] = 1'b0;
    bad = (tx_w[0] !== 1'b0) ? 1 : 0;
    repeat (38) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b0 || ready[0] !== 1'b0 || done[0] !== 1'b0) bad++;
    end
    check("t6 low", 32'(bad), 32'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy[0] !== 1'b1 || ready[0] !== 1'b0 || done[0] !== 1'b0) bad++;
    end
    check("t6 mark", 32'(bad), 32'd0);
    @(negedge clk);
    check("t6 idle", {28'd0, done[0], ready[0], busy[0], tx_w[0]}, 32'h5);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || done[0] !== 1'b0) bad++;
    end
    check("t6 nostart", 32'(bad), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
